image_rx_unpack: RTL
====================

# image_rx_unpack

Receive-side counterpart of the image line packetizer. Takes UDP payload words from the Ethernet receive path, one packet per image line, and recovers the line number. It serializes the 32-bit payload into a 16-bit pixel stream with line/frame markers for the frame-buffer write logic. It also checks packet length and line sequence and reports errors through sticky flags.

## Interface
- H_PIXEL, 640: pixels per output line; packet carries H_PIXEL/2 words (must be even).
- V_PIXEL, 480: lines per frame.
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- eth_rx_valid  in  1  payload word valid (at most one per 2 cycles).
- eth_rx_data  in  32  payload word.
- eth_rx_done  in  1  end-of-packet pulse, same cycle as or after last valid word.
- err_clr  in  1  clears all sticky error flags.
- pix_wr_en  out  1  pixel valid.
- pix_wr_data  out  16  pixel (RGB565).
- pix_line  out  16  line number of current packet.
- line_start  out  1  pulse with first pixel of a line.
- line_done  out  1  pulse after last pixel of a good line.
- frame_start  out  1  pulse with line_start when pix_line == 0.
- frame_done  out  1  pulse with line_done when pix_line == V_PIXEL-1.
- err_len, err_seq, err_ovf  out  1 each  sticky errors.

## Operation
- Packet format: word0[15:0] = line number, word0[31:16] = pixel 0; word k (1..H_PIXEL/2-1): [15:0] = pixel 2k-1, [31:16] = pixel 2k. The packet carries H_PIXEL-1 pixels. On a good packet the block emits one pad pixel equal to the last received pixel, giving H_PIXEL outputs.
- Input words enter a 4-deep word FIFO tagged with a header bit. A serializer reads one word and emits its pixels: header word gives 1 pixel, other words give 2 pixels, lower half first.
- States:
  - SYNC (after reset): discard words until eth_rx_done, then go to IDLE.
  - IDLE: first valid word is the header; go to PAYLOAD.
  - PAYLOAD: count words; on eth_rx_done go to CHECK.
  - CHECK: wait until the FIFO is empty and the serializer is idle, then go to IDLE.
  - DROP: discard words until eth_rx_done, then go to IDLE.
- Header with line ≥ V_PIXEL: set err_seq, go to DROP, emit no pixels.
- Sequence check: expected_line resets to 0.
  - Line 0 is always accepted and pulses frame_start.
  - Line != expected_line and != 0: set err_seq, packet still processed.
  - expected_line = line+1 after each good packet, wrapping to 0 after V_PIXEL-1.
- Length check, in CHECK: word count (including header and overflowed words) == H_PIXEL/2 means good. Good: emit pad pixel, then line_done. Otherwise: set err_len, no pad, no line_done, expected_line unchanged.
- Overflow: valid word while FIFO full is dropped and sets err_ovf; it still counts, and the packet gets no line_done.
- eth_rx_done in IDLE (empty packet): set err_len.
- err_clr clears flags in the next cycle; a set event in the same cycle wins.
- Word counter is 16 bits and saturates at 16'hFFFF.

## Timing
- Reset: all outputs 0, pix_line 0, FIFO empty, state SYNC, expected_line 0.
- Word accepted at cycle t into an empty FIFO with the serializer idle: its first pixel is on pix_wr_en at t+2. The second pixel of a non-header word follows at t+3.
- line_start/frame_start are coincident with pixel 0; pix_line is valid from that cycle until the next header.
- Pad pixel comes the cycle after the last data pixel; line_done/frame_done the cycle after the pad.
- Pixel output is continuous with no gaps while the FIFO is non-empty.
- eth_rx_done coincident with the last valid word counts that word.
- Reset mid-packet clears everything immediately; the rest of that packet is discarded via SYNC.

## Test plan
- Reset, dummy done, then a good packet for line 0 (320 words, pixel i = i): 640 pixels with values 0..638 then 638 again; frame_start and line_start with pixel 0; line_done 1 cycle after the pad; no errors.
- Lines 0..479 back-to-back: frame_done exactly once, with line 479's line_done; expected_line wraps to 0.
- Line 5 after line 2: err_seq = 1, pixels still emitted with pix_line = 5; err_clr then clears err_seq.
- Packet of 319 words: err_len = 1, 637 pixels, no pad, no line_done. Header line 480: err_seq = 1, zero pixels.
- Words on every cycle for 10 cycles: err_ovf = 1, no line_done; the next good packet recovers normally.
- Assert sys_rst mid-packet: outputs 0 immediately, remaining words produce no pixels; the next packet decodes correctly.

Source files
------------

// File: rtl/image_rx_unpack.sv
// Receive-side line depacketizer: UDP payload words in, RGB565 pixel stream out,
// with packet length / line sequence / overflow checking via sticky flags.
module image_rx_unpack #(
    parameter int H_PIXEL = 640,
    parameter int V_PIXEL = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        eth_rx_valid,
    input  logic [31:0] eth_rx_data,
    input  logic        eth_rx_done,
    input  logic        err_clr,
    output logic        pix_wr_en,
    output logic [15:0] pix_wr_data,
    output logic [15:0] pix_line,
    output logic        line_start,
    output logic        line_done,
    output logic        frame_start,
    output logic        frame_done,
    output logic        err_len,
    output logic        err_seq,
    output logic        err_ovf
);

    localparam logic [15:0] C_WORDS = 16'(H_PIXEL / 2);
    localparam logic [15:0] C_VPIX  = 16'(V_PIXEL);
    localparam logic [15:0] C_VLAST = 16'(V_PIXEL - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [32:0] r_fifo [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic        w_full;
    logic        w_empty;
    logic        w_wr;
    logic        w_pop;
    logic [32:0] w_head;

    logic [15:0] r_wcnt;
    logic [15:0] r_exp;
    logic [15:0] r_hdr_line;
    logic        r_pkt_ovf;
    logic [15:0] w_line;
    logic        w_hdr_take;
    logic        w_cnt_inc;
    logic        w_good;
    logic        w_set_len;
    logic        w_set_seq;
    logic        w_set_ovf;

    logic        r_pend;
    logic [15:0] r_hold;
    logic [15:0] r_last;
    logic        r_done_pend;

    logic        r_pix_wr_en;
    logic [15:0] r_pix_wr_data;
    logic [15:0] r_pix_line;
    logic        r_line_start;
    logic        r_line_done;
    logic        r_frame_start;
    logic        r_frame_done;
    logic        r_err_len;
    logic        r_err_seq;
    logic        r_err_ovf;

    assign w_full  = (r_count == 3'd4);
    assign w_empty = (r_count == 3'd0);
    assign w_head  = r_fifo[r_rptr];
    assign w_pop   = !w_empty && !r_pend;
    assign w_line  = eth_rx_data[15:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wr       = 1'b0;
        w_hdr_take = 1'b0;
        w_cnt_inc  = 1'b0;
        w_good     = 1'b0;
        w_set_len  = 1'b0;
        w_set_seq  = 1'b0;
        w_set_ovf  = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (eth_rx_done) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (eth_rx_valid) begin
                    if (w_line >= C_VPIX) begin
                        w_set_seq = 1'b1;
                        w_next    = eth_rx_done ? S_IDLE : S_DROP;
                    end else if (w_full) begin
                        w_set_ovf = 1'b1;
                        w_next    = eth_rx_done ? S_IDLE : S_DROP;
                    end else begin
                        w_wr       = 1'b1;
                        w_hdr_take = 1'b1;
                        w_set_seq  = (w_line != 16'd0) && (w_line != r_exp);
                        w_next     = eth_rx_done ? S_CHECK : S_PAYLOAD;
                    end
                end else if (eth_rx_done) begin
                    w_set_len = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (eth_rx_valid) begin
                    w_cnt_inc = 1'b1;
                    w_wr      = !w_full;
                    w_set_ovf = w_full;
                end
                if (eth_rx_done) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                // Decide only once every accepted pixel has left the serializer
                if (w_empty && !r_pend) begin
                    w_next    = S_IDLE;
                    w_set_len = (r_wcnt != C_WORDS);
                    w_good    = (r_wcnt == C_WORDS) && !r_pkt_ovf;
                end
            end
            S_DROP: begin
                if (eth_rx_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) begin
            r_fifo[r_wptr] <= {w_hdr_take, eth_rx_data};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wcnt     <= 16'd0;
            r_exp      <= 16'd0;
            r_hdr_line <= 16'd0;
            r_pkt_ovf  <= 1'b0;
        end else begin
            if (w_hdr_take) begin
                r_wcnt     <= 16'd1;
                r_hdr_line <= w_line;
                r_pkt_ovf  <= 1'b0;
            end else if (w_cnt_inc && (r_wcnt != 16'hFFFF)) begin
                r_wcnt <= r_wcnt + 16'd1;
            end
            if (w_set_ovf) begin
                r_pkt_ovf <= 1'b1;
            end
            if (w_good) begin
                r_exp <= (r_hdr_line == C_VLAST) ? 16'd0 : r_hdr_line + 16'd1;
            end
        end
    end

    // A new error event takes priority over a simultaneous clear
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_err_len <= 1'b0;
            r_err_seq <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_err_len <= w_set_len | (r_err_len & ~err_clr);
            r_err_seq <= w_set_seq | (r_err_seq & ~err_clr);
            r_err_ovf <= w_set_ovf | (r_err_ovf & ~err_clr);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pend        <= 1'b0;
            r_hold        <= 16'd0;
            r_last        <= 16'd0;
            r_done_pend   <= 1'b0;
            r_pix_wr_en   <= 1'b0;
            r_pix_wr_data <= 16'd0;
            r_pix_line    <= 16'd0;
            r_line_start  <= 1'b0;
            r_line_done   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_pix_wr_en   <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_done_pend   <= 1'b0;
            r_line_done   <= r_done_pend;
            r_frame_done  <= r_done_pend && (r_pix_line == C_VLAST);
            if (w_pop) begin
                r_pix_wr_en <= 1'b1;
                if (w_head[32]) begin
                    r_pix_wr_data <= w_head[31:16];
                    r_last        <= w_head[31:16];
                    r_pix_line    <= w_head[15:0];
                    r_line_start  <= 1'b1;
                    r_frame_start <= (w_head[15:0] == 16'd0);
                end else begin
                    r_pix_wr_data <= w_head[15:0];
                    r_last        <= w_head[15:0];
                    r_hold        <= w_head[31:16];
                    r_pend        <= 1'b1;
                end
            end else if (r_pend) begin
                r_pix_wr_en   <= 1'b1;
                r_pix_wr_data <= r_hold;
                r_last        <= r_hold;
                r_pend        <= 1'b0;
            end else if (w_good) begin
                // Pad pixel repeats the last received one to fill the line
                r_pix_wr_en   <= 1'b1;
                r_pix_wr_data <= r_last;
                r_done_pend   <= 1'b1;
            end
        end
    end

    assign pix_wr_en   = r_pix_wr_en;
    assign pix_wr_data = r_pix_wr_data;
    assign pix_line    = r_pix_line;
    assign line_start  = r_line_start;
    assign line_done   = r_line_done;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign err_len     = r_err_len;
    assign err_seq     = r_err_seq;
    assign err_ovf     = r_err_ovf;

endmodule
